// File: rtl/id_stage_reg_fwd.sv
// rtl/id_stage_reg_fwd.sv - Decode-stage PC/instruction register with operand forwarding select,
// load-use stall generation, flush, valid tracking and a saturating stall counter.
module id_stage_reg_fwd #(
  parameter int PC_W    = 8,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 16,
  localparam int SEL_W  = $clog2(NUM_FWD + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_signal_in,
  input  logic                 D_stop,
  input  logic                 jump_reset,
  input  logic [PC_W-1:0]      pc_in,
  input  logic [31:0]          inst_in,
  input  logic [5*NUM_FWD-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]   fwd_we,
  input  logic [NUM_FWD-1:0]   fwd_is_load,
  output logic [PC_W-1:0]      pc_out,
  output logic [31:0]          inst_out,
  output logic                 valid_out,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [SEL_W-1:0]     r1_sel,
  output logic [SEL_W-1:0]     r2_sel,
  output logic                 lu_stall,
  output logic [CNT_W-1:0]     lu_stall_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, RUN, LU_STALL} state_t;

  state_t          state;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     inst_q;
  logic            valid_q;
  logic            use_rs1;
  logic            use_rs2;

  // Only the youngest source can still be waiting on load data.
  logic unused_load_bits;
  assign unused_load_bits = &{1'b0, fwd_is_load[NUM_FWD-1:1]};

  assign rs1 = inst_q[19:15];
  assign rs2 = inst_q[24:20];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (inst_q[6:0])
      7'b1100111, 7'b0000011, 7'b0010011: use_rs1 = 1'b1;
      7'b1100011, 7'b0100011, 7'b0110011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // Walk oldest to youngest so the youngest matching source wins.
  always_comb begin
    r1_sel = '0;
    r2_sel = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (use_rs1 && rs1 != 5'd0 && fwd_we[i] && fwd_rd[5*i +: 5] == rs1)
        r1_sel = SEL_W'(i + 1);
      if (use_rs2 && rs2 != 5'd0 && fwd_we[i] && fwd_rd[5*i +: 5] == rs2)
        r2_sel = SEL_W'(i + 1);
    end
  end

  // A sel of 1 already implies a source-0 match on a used, non-x0 operand.
  assign lu_stall = valid_q && state == RUN && fwd_is_load[0] && fwd_we[0] &&
                    (r1_sel == SEL_W'(1) || r2_sel == SEL_W'(1));

  assign pc_out    = pc_q;
  assign inst_out  = lu_stall ? NOP : inst_q;
  assign valid_out = valid_q && !lu_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= '0;
      inst_q       <= NOP;
      valid_q      <= 1'b0;
      state        <= IDLE;
      lu_stall_cnt <= '0;
    end else begin
      if (lu_stall && lu_stall_cnt != '1)
        lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);

      if (!start_signal_in) begin
        pc_q    <= '0;
        inst_q  <= NOP;
        valid_q <= 1'b0;
        state   <= IDLE;
      end else begin
        if (jump_reset) begin
          inst_q  <= NOP;
          valid_q <= 1'b0;
        end else if (!(D_stop || lu_stall)) begin
          pc_q    <= pc_in;
          inst_q  <= inst_in;
          valid_q <= 1'b1;
        end

        case (state)
          IDLE:     state <= RUN;
          RUN:      if (lu_stall && !jump_reset) state <= LU_STALL;
          LU_STALL: if (!D_stop) state <= RUN;
          default:  state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_stage_reg_fwd.sv
// tb/tb_id_stage_reg_fwd.sv - Directed self-checking bench for id_stage_reg_fwd (CNT_W=2).
module tb_id_stage_reg_fwd;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] ADD_3_1_2 = 32'h0020_81B3;
  localparam logic [31:0] ADD_6_5_7 = 32'h0072_8333;
  localparam logic [31:0] ADD_4_0_0 = 32'h0000_0233;
  localparam logic [31:0] ADDI_3_1  = 32'h0020_8193;
  localparam logic [31:0] LUI_1     = 32'h0000_80B7;

  logic        clk = 1'b0;
  logic        rst, start_signal_in, D_stop, jump_reset;
  logic [7:0]  pc_in;
  logic [31:0] inst_in;
  logic [14:0] fwd_rd;
  logic [2:0]  fwd_we, fwd_is_load;
  logic [7:0]  pc_out;
  logic [31:0] inst_out;
  logic        valid_out, lu_stall;
  logic [4:0]  rs1, rs2;
  logic [1:0]  r1_sel, r2_sel, lu_stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_cnt;

  always #5 clk = ~clk;

  id_stage_reg_fwd #(.PC_W(8), .NUM_FWD(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .start_signal_in(start_signal_in), .D_stop(D_stop),
    .jump_reset(jump_reset), .pc_in(pc_in), .inst_in(inst_in), .fwd_rd(fwd_rd),
    .fwd_we(fwd_we), .fwd_is_load(fwd_is_load), .pc_out(pc_out), .inst_out(inst_out),
    .valid_out(valid_out), .rs1(rs1), .rs2(rs2), .r1_sel(r1_sel), .r2_sel(r2_sel),
    .lu_stall(lu_stall), .lu_stall_cnt(lu_stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_signal_in = 1'b0; D_stop = 1'b0; jump_reset = 1'b0;
    pc_in = 8'h00; inst_in = NOP; fwd_rd = '0; fwd_we = '0; fwd_is_load = '0;
    step(); step();
    checks++; if (pc_out !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", pc_out); end
    checks++; if (inst_out !== NOP) begin errors++; $display("FAIL reset_inst got %h exp %h", inst_out, NOP); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_out); end
    checks++; if ({r1_sel, r2_sel} !== 4'b0) begin errors++; $display("FAIL reset_sel got %b%b exp 0000", r1_sel, r2_sel); end
    checks++; if (lu_stall_cnt !== 2'd0 || lu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got cnt %0d lu %b exp 0 0", lu_stall_cnt, lu_stall); end
    rst = 1'b0;
  endtask

  task automatic test_load_path();
    start_signal_in = 1'b1; pc_in = 8'h10; inst_in = ADD_3_1_2;
    step();
    fwd_rd = {5'd1, 5'd1, 5'd5}; fwd_we = 3'b111; fwd_is_load = 3'b000;
    #1;
    checks++; if (pc_out !== 8'h10 || inst_out !== ADD_3_1_2 || valid_out !== 1'b1) begin
      errors++; $display("FAIL load_regs got %h %h %b exp 10 %h 1", pc_out, inst_out, valid_out, ADD_3_1_2); end
    checks++; if (r1_sel !== 2'd2) begin errors++; $display("FAIL fwd_m_beats_w got %0d exp 2", r1_sel); end
    checks++; if (r2_sel !== 2'd0) begin errors++; $display("FAIL fwd_r2_none got %0d exp 0", r2_sel); end
    // addi: rs2 field is immediate, rs1 only from W
    fwd_we = '0; inst_in = ADDI_3_1; pc_in = 8'h12;
    step();
    fwd_rd = {5'd1, 5'd2, 5'd2}; fwd_we = 3'b111;
    #1;
    checks++; if (r1_sel !== 2'd3 || r2_sel !== 2'd0) begin
      errors++; $display("FAIL opimm_sel got %0d %0d exp 3 0", r1_sel, r2_sel); end
    fwd_we = '0;
  endtask

  task automatic test_load_use();
    pc_in = 8'h14; inst_in = ADD_6_5_7;
    step();
    pc_in = 8'h18; inst_in = ADDI_3_1;
    fwd_rd = {5'd0, 5'd0, 5'd5}; fwd_we = 3'b001; fwd_is_load = 3'b001;
    #1;
    checks++; if (lu_stall !== 1'b1 || inst_out !== NOP || valid_out !== 1'b0) begin
      errors++; $display("FAIL lu_detect got %b %h %b exp 1 %h 0", lu_stall, inst_out, valid_out, NOP); end
    step();
    exp_cnt = 2'd1;
    fwd_rd = {5'd0, 5'd5, 5'd0}; fwd_we = 3'b010; fwd_is_load = 3'b000;
    #1;
    checks++; if (lu_stall !== 1'b0 || inst_out !== ADD_6_5_7 || pc_out !== 8'h14 || valid_out !== 1'b1) begin
      errors++; $display("FAIL lu_release got %b %h %h %b exp 0 %h 14 1", lu_stall, inst_out, pc_out, valid_out, ADD_6_5_7); end
    checks++; if (r1_sel !== 2'd2) begin errors++; $display("FAIL lu_fwd_m got %0d exp 2", r1_sel); end
    checks++; if (lu_stall_cnt !== exp_cnt) begin errors++; $display("FAIL lu_cnt got %0d exp %0d", lu_stall_cnt, exp_cnt); end
    step();
    fwd_we = '0;
    checks++; if (pc_out !== 8'h18 || inst_out !== ADDI_3_1) begin
      errors++; $display("FAIL lu_advance got %h %h exp 18 %h", pc_out, inst_out, ADDI_3_1); end
  endtask

  task automatic test_stop_flush();
    D_stop = 1'b1; pc_in = 8'h1C; inst_in = ADD_3_1_2;
    step();
    checks++; if (pc_out !== 8'h18 || inst_out !== ADDI_3_1) begin
      errors++; $display("FAIL dstop_hold got %h %h exp 18 %h", pc_out, inst_out, ADDI_3_1); end
    jump_reset = 1'b1;
    step();
    checks++; if (inst_out !== NOP || valid_out !== 1'b0) begin
      errors++; $display("FAIL flush_over_stall got %h %b exp %h 0", inst_out, valid_out, NOP); end
    D_stop = 1'b0; jump_reset = 1'b0;
  endtask

  task automatic test_x0_and_unused();
    inst_in = ADD_4_0_0; pc_in = 8'h20;
    step();
    fwd_rd = {5'd0, 5'd0, 5'd0}; fwd_we = 3'b111; fwd_is_load = 3'b001;
    #1;
    checks++; if (r1_sel !== 2'd0 || r2_sel !== 2'd0 || lu_stall !== 1'b0) begin
      errors++; $display("FAIL x0_never_fwd got %0d %0d %b exp 0 0 0", r1_sel, r2_sel, lu_stall); end
    fwd_we = '0; fwd_is_load = '0; inst_in = LUI_1; pc_in = 8'h24;
    step();
    fwd_rd = {5'd1, 5'd1, 5'd1}; fwd_we = 3'b111; fwd_is_load = 3'b001;
    #1;
    checks++; if (r1_sel !== 2'd0 || lu_stall !== 1'b0) begin
      errors++; $display("FAIL unused_operand got %0d %b exp 0 0", r1_sel, lu_stall); end
    fwd_we = '0; fwd_is_load = '0;
  endtask

  task automatic test_start_low();
    start_signal_in = 1'b0;
    step();
    checks++; if (pc_out !== 8'h00 || inst_out !== NOP || valid_out !== 1'b0 || lu_stall_cnt !== exp_cnt) begin
      errors++; $display("FAIL start_low got %h %h %b cnt %0d exp 00 %h 0 %0d", pc_out, inst_out, valid_out, lu_stall_cnt, NOP, exp_cnt); end
    start_signal_in = 1'b1;
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 5; k++) begin
      inst_in = ADD_6_5_7; pc_in = 8'h40 + 8'(k);
      step();
      inst_in = NOP;
      fwd_rd = {5'd0, 5'd0, 5'd5}; fwd_we = 3'b001; fwd_is_load = 3'b001;
      step();
      if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      fwd_we = '0; fwd_is_load = '0;
      checks++; if (lu_stall_cnt !== exp_cnt) begin
        errors++; $display("FAIL sat_cnt_%0d got %0d exp %0d", k, lu_stall_cnt, exp_cnt); end
      step();
    end
  endtask

  task automatic test_reset_mid_stall();
    inst_in = ADD_6_5_7; pc_in = 8'h60;
    step();
    fwd_rd = {5'd0, 5'd0, 5'd5}; fwd_we = 3'b001; fwd_is_load = 3'b001;
    rst = 1'b1;
    step();
    rst = 1'b0; start_signal_in = 1'b0;
    #1;
    checks++; if (inst_out !== NOP || valid_out !== 1'b0 || pc_out !== 8'h00 || lu_stall_cnt !== 2'd0 || lu_stall !== 1'b0) begin
      errors++; $display("FAIL reset_mid_stall got %h %b %h %0d %b exp %h 0 00 0 0", inst_out, valid_out, pc_out, lu_stall_cnt, lu_stall, NOP); end
  endtask

  initial begin
    exp_cnt = 2'd0;
    test_reset();
    test_load_path();
    test_load_use();
    test_stop_flush();
    test_x0_and_unused();
    test_start_low();
    test_saturate();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
